pending_drain: RTL and testbench

- Sits directly downstream of the W-bit set/clear request latch (latch1).
- Takes the latch's accumulated pending bits as a snapshot and issues a one-cycle clear back to the latch.
- Serves each snapshotted bit in round-robin order to a consumer (channel/status logic) over a valid/ready handshake.
- Converts a sticky bit-vector into a serial stream of bit indices without losing events.

---
 rtl/pending_drain_pkg.sv | 24 ++
 rtl/pending_drain_rr_pick.sv | 37 +++
 rtl/pending_drain.sv | 92 +++++++++
 tb/tb_pending_drain.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pending_drain_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : x2821_pkg
//  Description : Shared state encoding and width helper for pending_drain.
//  Revision    : 1.0 - initial release
// ============================================================================
package x2821_pkg;

  // FSM state encoding
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  // Ceiling log2 for elaboration-time width computation
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < value) r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pending_drain_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Round-robin pick of the first set bit at or above a pointer,
//                wrapping from W-1 to 0, via a doubled-vector mask.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
  import x2821_pkg::*;
#(
  parameter int W = 4,
  localparam int IW = (clog2(W) < 1) ? 1 : clog2(W)
) (
  input  logic [W-1:0]  vec_i,
  input  logic [IW-1:0] ptr_i,
  output logic          any_o,
  output logic [IW-1:0] idx_o
);

  logic [2*W-1:0] dbl_w;

  assign dbl_w = {vec_i, vec_i};
  assign any_o = |vec_i;

  // Scan downward so the lowest qualifying position of the doubled vector wins;
  // the upper copy supplies the wrapped candidates below the pointer.
  always_comb begin
    idx_o = '0;
    for (int i = 2*W-1; i >= 0; i--) begin
      if (dbl_w[i] && (i >= int'(ptr_i))) begin
        idx_o = IW'(i % W);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/pending_drain.sv
`default_nettype none
// ============================================================================
//  Module      : pending_drain
//  Description : Snapshots a sticky pending vector, clears the source latch
//                once, and serves each captured bit in round-robin order over
//                a valid/ready handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module pending_drain
  import x2821_pkg::*;
#(
  parameter int W = 4,
  localparam int IW = (clog2(W) < 1) ? 1 : clog2(W)
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic [W-1:0]  i_pending,
  output logic          o_clear,
  output logic          o_valid,
  output logic [IW-1:0] o_index,
  input  logic          i_ready,
  output logic          o_busy
);

  logic [0:0]    state_q, state_d;
  logic [W-1:0]  snap_q, snap_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic          clear_q, clear_d;

  logic          pick_any_w;
  logic [IW-1:0] pick_idx_w;
  logic [IW-1:0] next_ptr_w;
  logic [W-1:0]  onehot_w;

  rr_pick #(.W(W)) u_pick (
    .vec_i (snap_q),
    .ptr_i (ptr_q),
    .any_o (pick_any_w),
    .idx_o (pick_idx_w)
  );

  assign onehot_w   = W'(1) << pick_idx_w;
  assign next_ptr_w = (int'(pick_idx_w) == W-1) ? '0 : pick_idx_w + IW'(1);

  // Outputs depend only on registered state; no path from i_pending or i_ready.
  assign o_clear = clear_q;
  assign o_valid = (state_q == ST_DRAIN) && pick_any_w;
  assign o_index = (state_q == ST_DRAIN) ? pick_idx_w : '0;
  assign o_busy  = (state_q != ST_IDLE);

  // Next-state: capture in IDLE, retire one bit per accepted grant in DRAIN
  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    ptr_d   = ptr_q;
    clear_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|i_pending) begin
          snap_d  = i_pending;
          state_d = ST_DRAIN;
          clear_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (i_ready) begin
          snap_d = snap_q & ~onehot_w;
          ptr_d  = next_ptr_w;
          if ((snap_q & ~onehot_w) == '0) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers; async reset discards any in-flight snapshot
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      ptr_q   <= '0;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      ptr_q   <= ptr_d;
      clear_q <= clear_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pending_drain.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pending_drain
//  Description : Directed self-checking bench for pending_drain, with a
//                set-priority latch model feeding i_pending.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pending_drain;

  logic       clk;
  logic       rst_n;
  logic [3:0] set_req;
  logic [3:0] latch_q;
  logic       ovr_en;
  logic [3:0] ovr_val;
  logic [3:0] pending;
  logic       clear;
  logic       valid;
  logic [1:0] index;
  logic       ready;
  logic       busy;
  int         checks;
  int         errors;
  int         clear_cnt;

  pending_drain #(.W(4)) dut (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_pending (pending),
    .o_clear   (clear),
    .o_valid   (valid),
    .o_index   (index),
    .i_ready   (ready),
    .o_busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Upstream latch: set has priority over clear
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) latch_q <= 4'h0;
    else        latch_q <= set_req | (clear ? 4'h0 : latch_q);
  end

  assign pending = ovr_en ? ovr_val : latch_q;

  always @(negedge clk) if (clear) clear_cnt <= clear_cnt + 1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_set(input logic [3:0] bits);
    set_req = bits;
    tick();
    set_req = 4'h0;
  endtask

  task automatic test_reset;
    ovr_en = 1'b1; ovr_val = 4'hF; rst_n = 1'b0;
    tick(); tick();
    checks++;
    if (clear !== 1'b0 || valid !== 1'b0 || busy !== 1'b0 || index !== 2'd0) begin
      errors++;
      $display("FAIL reset_hold: clear=%b valid=%b busy=%b index=%0d, required 0/0/0/0", clear, valid, busy, index);
    end
    ovr_en = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (clear !== 1'b0 || valid !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle[%0d]: clear=%b valid=%b busy=%b, required 0/0/0", i, clear, valid, busy);
      end
    end
  endtask

  // Serve a snapshot with ready high and check the index sequence
  task automatic drain_expect(input string name, input logic [3:0] bits,
                              input int n, input logic [1:0] e0, input logic [1:0] e1);
    ready = 1'b1;
    clear_cnt = 0;
    pulse_set(bits);
    tick();
    checks++;
    if (clear !== 1'b1 || valid !== 1'b1 || index !== e0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_first: clear=%b valid=%b index=%0d busy=%b, required 1/1/%0d/1", name, clear, valid, index, busy, e0);
    end
    if (n == 2) begin
      tick();
      checks++;
      if (clear !== 1'b0 || valid !== 1'b1 || index !== e1) begin
        errors++;
        $display("FAIL %s_second: clear=%b valid=%b index=%0d, required 0/1/%0d", name, clear, valid, index, e1);
      end
    end
    tick();
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || clear !== 1'b0 || clear_cnt !== 1) begin
      errors++;
      $display("FAIL %s_done: valid=%b busy=%b clear=%b clear_pulses=%0d, required 0/0/0/1", name, valid, busy, clear, clear_cnt);
    end
  endtask

  task automatic test_round_robin;
    drain_expect("basic_1010", 4'b1010, 2, 2'd1, 2'd3);
    drain_expect("rr_0110",    4'b0110, 2, 2'd1, 2'd2);
    drain_expect("wrap_1001",  4'b1001, 2, 2'd3, 2'd0);
  endtask

  task automatic test_stall;
    ready = 1'b0;
    pulse_set(4'b0100);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (valid !== 1'b1 || index !== 2'd2 || clear !== (i == 0)) begin
        errors++;
        $display("FAIL stall[%0d]: valid=%b index=%0d clear=%b, required 1/2/%0d", i, valid, index, clear, (i == 0));
      end
    end
    ready = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: valid=%b busy=%b, required 0/0", valid, busy);
    end
  endtask

  task automatic test_arrival_during_drain;
    ready = 1'b0;
    clear_cnt = 0;
    pulse_set(4'b0001);
    tick();
    checks++;
    if (clear !== 1'b1 || valid !== 1'b1 || index !== 2'd0) begin
      errors++;
      $display("FAIL arrive_first: clear=%b valid=%b index=%0d, required 1/1/0", clear, valid, index);
    end
    pulse_set(4'b1000);
    tick();
    checks++;
    if (clear !== 1'b0 || valid !== 1'b1 || index !== 2'd0) begin
      errors++;
      $display("FAIL arrive_hold: clear=%b valid=%b index=%0d, required 0/1/0", clear, valid, index);
    end
    ready = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL arrive_gap: valid=%b busy=%b, required 0/0", valid, busy);
    end
    tick();
    checks++;
    if (clear !== 1'b1 || valid !== 1'b1 || index !== 2'd3) begin
      errors++;
      $display("FAIL arrive_recapture: clear=%b valid=%b index=%0d, required 1/1/3", clear, valid, index);
    end
    tick();
    tick();
    checks++;
    if (valid !== 1'b0 || clear_cnt !== 2) begin
      errors++;
      $display("FAIL arrive_clears: valid=%b clear_pulses=%0d, required 0/2", valid, clear_cnt);
    end
  endtask

  task automatic test_reset_mid_drain;
    ready = 1'b1;
    pulse_set(4'b1100);
    tick();
    tick();
    checks++;
    if (valid !== 1'b1 || index !== 2'd3) begin
      errors++;
      $display("FAIL midrst_pre: valid=%b index=%0d, required 1/3", valid, index);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || clear !== 1'b0) begin
      errors++;
      $display("FAIL midrst_async: valid=%b busy=%b clear=%b, required 0/0/0", valid, busy, clear);
    end
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (valid !== 1'b0 || clear !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL midrst_quiet[%0d]: valid=%b clear=%b busy=%b, required 0/0/0", i, valid, clear, busy);
      end
    end
    // Pointer back at 0: 1010 must start at index 1, not 3
    drain_expect("midrst_ptr", 4'b1010, 2, 2'd1, 2'd3);
  endtask

  initial begin
    rst_n = 1'b0; set_req = 4'h0; ovr_en = 1'b0; ovr_val = 4'h0;
    ready = 1'b0; checks = 0; errors = 0; clear_cnt = 0;
    test_reset();
    test_round_robin();
    test_stall();
    test_arrival_during_drain();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
